// File: rtl/pc_fetch_ctrl_if.sv
// Bundle between the fetch controller and its neighbours: instruction memory,
// decode, the next-PC unit, plus halt and status signals.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] PC;
    logic        work_IF;
    logic        work_EX;
    logic [31:0] NPC;
    logic        npc_valid;
    logic        halt;
    logic [1:0]  err;
    logic [31:0] retired;

    // Fetch controller side
    modport master (
        output imem_req, imem_addr, instr, instr_valid, PC, work_IF, work_EX, err, retired,
        input  imem_ack, imem_rdata, instr_ready, NPC, npc_valid, halt
    );

    // Environment side (memory, decode, next-PC unit)
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, PC, work_IF, work_EX, err, retired,
        output imem_ack, imem_rdata, instr_ready, NPC, npc_valid, halt
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: request, wait for memory, hand the word to
// decode, let the next-PC unit resolve, then commit the new PC.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rstn,
    pc_fetch_ctrl_if.master bus
);
    localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, EXEC, UPDATE, STOP} state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_instr;
    logic [31:0]         r_npc;
    logic [31:0]         r_retired;
    logic [1:0]          r_err;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_imem_req;
    logic                r_instr_valid;
    logic                r_work_if;
    logic                r_work_ex;
    logic                r_halt_pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_npc         <= '0;
            r_retired     <= '0;
            r_err         <= 2'b00;
            r_wait_cnt    <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_work_if     <= 1'b0;
            r_work_ex     <= 1'b0;
            r_halt_pend   <= 1'b0;
        end else begin
            // Halt outside an instruction boundary waits for the next UPDATE
            if (bus.halt && r_state != IDLE && r_state != UPDATE)
                r_halt_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (!bus.halt) begin
                        r_state    <= REQ;
                        r_imem_req <= 1'b1;
                        r_work_if  <= 1'b1;
                    end
                end
                REQ: begin
                    r_work_if  <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end else if (r_wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                        r_imem_req <= 1'b0;
                        if (r_err == 2'b00)
                            r_err <= 2'b10;
                        r_state    <= STOP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_work_ex     <= 1'b1;
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.npc_valid) begin
                        r_npc     <= bus.NPC;
                        r_work_ex <= 1'b0;
                        r_state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (r_npc[1:0] == 2'b00) begin
                        r_pc      <= r_npc;
                        r_retired <= r_retired + 32'd1;
                        if (bus.halt || r_halt_pend) begin
                            r_state <= STOP;
                        end else begin
                            r_state    <= REQ;
                            r_imem_req <= 1'b1;
                            r_work_if  <= 1'b1;
                        end
                    end else begin
                        if (r_err == 2'b00)
                            r_err <= 2'b01;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                end
                default: r_state <= STOP;
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.PC          = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.work_IF     = r_work_if;
    assign bus.work_EX     = r_work_ex;
    assign bus.err         = r_err;
    assign bus.retired     = r_retired;
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 8: maximum cycles to wait for imem_ack before the fetch is flagged as failed.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  fetch address; always equals PC.
REQ-007 imem_ack  input  1  memory reports that imem_rdata is valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  latched instruction presented to decode.
REQ-010 instr_valid  output  1  instr is valid and offered to decode.
REQ-011 instr_ready  input  1  decode accepts instr.
REQ-012 PC  output  32  current program counter, fed to the next-PC unit.
REQ-013 work_IF  output  1  one-cycle strobe telling the next-PC unit to capture PC and PC+4.
REQ-014 work_EX  output  1  level telling the next-PC unit to resolve the next PC.
REQ-015 NPC  input  32  resolved next PC from the next-PC unit.
REQ-016 npc_valid  input  1  NPC is final; sampled only while work_EX=1.
REQ-017 halt  input  1  synchronous request to stop fetching at the next instruction boundary.
REQ-018 err  output  2  sticky error code: 00 none, 01 misaligned NPC, 10 fetch timeout.
REQ-019 retired  output  32  count of completed PC updates.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, ISSUE, EXEC, UPDATE, and STOP.
REQ-021 IDLE SHALL go to REQ on the first clock after reset release, unless halt=1.
REQ-022 In REQ, imem_req SHALL be 1 for exactly one cycle and work_IF SHALL be 1 in that same cycle; next state is WAIT.
REQ-023 In WAIT, imem_req SHALL stay 1 until imem_ack is seen; an ack in REQ's cycle is ignored.
- On imem_ack=1: instr SHALL latch imem_rdata and the FSM SHALL go to ISSUE.
- On timeout (ACK_TIMEOUT cycles in WAIT with no ack): err SHALL become 10 and the FSM SHALL go to STOP.
REQ-024 In ISSUE, instr_valid SHALL be 1 and instr SHALL hold stable until instr_ready=1; the handshake cycle moves to EXEC.
REQ-025 In EXEC, work_EX SHALL be 1 and the block SHALL wait for npc_valid.
- NPC SHALL be captured in the cycle npc_valid=1, then the FSM goes to UPDATE.
REQ-026 In UPDATE:
- If NPC[1:0]==00: PC SHALL take the captured NPC, retired SHALL increment by 1 (wrapping 32'hFFFF_FFFF to 0), and the next state is REQ, or STOP if halt=1.
- If NPC[1:0]!=00: PC SHALL be left unchanged, err SHALL become 01, and the next state is STOP.
REQ-027 STOP is terminal: no request is issued and every output holds its value until reset.
REQ-028 halt seen in any state other than IDLE or UPDATE SHALL be deferred to the next UPDATE; the current instruction always completes.
REQ-029 Minimum latency per instruction (ack arriving in the first WAIT cycle, ready and npc_valid immediate) SHALL be 5 cycles, REQ to REQ.
REQ-030 work_IF and work_EX SHALL never both be 1; imem_req SHALL be 0 outside REQ and WAIT.
REQ-031 err SHALL record only the first error; later errors do not overwrite it.

Reset
REQ-032 When rstn=0, the block SHALL immediately return to IDLE with these values:
- PC = RESET_PC
- instr, retired, err = 0
- imem_req, instr_valid, work_IF, work_EX = 0
REQ-033 Reset asserted mid-fetch or mid-EXEC SHALL abandon the transaction; an imem_ack arriving after reset release while not in WAIT SHALL be ignored.

Verification
REQ-034 Reset release, ack on first WAIT cycle, instr_ready=1, NPC=32'h3004 -> imem_addr=32'h3000, one work_IF pulse, then PC=32'h3004, retired=1, 5 cycles REQ to REQ.
REQ-035 imem_ack delayed 3 cycles and instr_ready held 0 for 2 cycles -> imem_req held through WAIT, instr stable while instr_valid=1, no work_EX before the handshake.
REQ-036 NPC=32'h3002 with npc_valid -> err=01, PC stays 32'h3000, state STOP, no further imem_req.
REQ-037 imem_ack never asserted -> after 8 WAIT cycles err=10 and imem_req=0 permanently.
REQ-038 halt pulsed during ISSUE -> the instruction completes, PC updates, retired increments, then STOP with no new REQ.
REQ-039 rstn dropped while in EXEC -> all outputs take reset values immediately; the next fetch after release is at RESET_PC.
